regread_stage: RTL
==================

# regread_stage

Register-read / issue stage of the 16-bit CPU, sitting between decode and execute. It selects two source operands from the eight register-file outputs, tracks pending writes with an 8-entry scoreboard, and stalls on RAW/WAW hazards. Operands, destination and control bits are held in a registered valid/ready slot for execute. It also snoops the write-back bus that drives the register file, to forward and to retire scoreboard entries.

## Interface
Parameters:
- CTL_W, 8, width of opaque control bits passed decode → execute

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- q0..q7  in  16 each  register-file outputs
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rsa, in_rsb  in  3 each  source register selects
- in_rd  in  3  destination register
- in_wen  in  1  instruction writes in_rd
- in_ctl  in  CTL_W  passthrough control
- wb_load, wb_wsel, wb_d  in  1/3/16  write-back bus (same signals as register-file load/wsel/d)
- out_valid  out  1  slot holds an issued instruction
- out_ready  in  1  execute accepts slot
- out_a, out_b  out  16 each  operand values
- out_rd, out_wen, out_ctl  out  3/1/CTL_W  registered passthrough
- busy  out  8  scoreboard bits, bit i = write to register i pending

## Operation
- Scoreboard, per register i:
  - Set on the issue edge when in_wen and in_rd==i.
  - Cleared on the edge when wb_load and wb_wsel==i.
  - Simultaneous set and clear on the same register: set wins.
- Source hazard on rsX:
  - busy[rsX] and not (wb_load and wb_wsel==rsX), with forwarding enabled.
  - busy[rsX], with forwarding disabled.
- WAW hazard: in_wen and busy[in_rd] and not (wb_load and wb_wsel==in_rd).
- hazard = source hazard on rsa or rsb, or WAW hazard. Sources are checked regardless of whether the instruction uses them; decode points unused selects at a non-busy register.
- in_ready = !hazard and (!out_valid or out_ready). in_ready depends on in_* combinationally; decode must not make in_valid depend on in_ready.
- Issue (in_valid and in_ready): slot loads out_a = operand(rsa), out_b = operand(rsb), plus rd/wen/ctl; out_valid ← 1.
- operand(r) = wb_d when forwarding is enabled, wb_load and wb_wsel==r; otherwise q_r.
- Slot drained without a new issue (out_valid, out_ready, no issue): out_valid ← 0. The remaining slot fields hold their old values.
- Slot stalled (out_valid and !out_ready): all slot fields hold.
- Operands are captured at issue and never refreshed afterwards. The scoreboard guarantees they are final.
- Registers have no special cases: register 0 is a normal register.

## Timing
- Reset values: out_valid 0, out_a 0, out_b 0, out_rd 0, out_wen 0, out_ctl 0, busy 8'h00. in_ready = !out_valid and no hazard, which is 1 after reset since busy is clear.
- Latency is one cycle, from the issue edge to out_valid high.
- Throughput is one instruction per cycle with no hazards and out_ready held high.
- RAW with forwarding: the dependent instruction issues in the same cycle the write-back appears on the bus.
- RAW without forwarding: the dependent instruction issues one cycle after the write-back cycle, reading the updated q.
- A write-back to a non-busy register is legal and leaves busy at 0.
- RSTN asserted mid-operation clears the slot and the scoreboard immediately, regardless of CLK.

## Configuration
- REGREAD_BYPASS_EN defined:
  - Write-back data is forwarded to operands.
  - A write-back in the current cycle masks the source and WAW hazards for that register.
- REGREAD_BYPASS_EN undefined:
  - No forwarding mux.
  - Hazards use busy only.
  - Each RAW dependence costs one extra stall cycle.
- Port list is identical in both builds.

## Structure
- Shared package cpu_pkg: REG_W=16, REG_N=8, SEL_W=3, and typedef reg_sel_t (3-bit).
- One sub-module, reg_scoreboard:
  - Holds the busy register and its set/clear logic.
  - Produces the hazard outputs for given selects and the write-back snoop.
- The top level holds the operand muxes, forwarding, and the output slot.

## Test plan
- Reset, then issue rsa=1, rsb=2 with q1=16'h0011, q2=16'h0022, wen=0 → next cycle out_valid=1, out_a=16'h0011, out_b=16'h0022, busy=0.
- Issue a write to rd=3, then a reader of rsa=3; write-back wb_wsel=3, wb_d=16'hBEEF two cycles later:
  - in_ready=0 until write-back.
  - With forwarding: issue in the write-back cycle, out_a=16'hBEEF, busy[3]=0.
  - Without forwarding: issue one cycle later.
- out_ready=0 for 3 cycles with the slot full → in_ready=0, out_* stable; release → slot drains, next instruction issues in the same cycle.
- WAW: rd=5 pending, second instruction with rd=5, wen=1 → stall until wb_wsel=5; busy[5] stays 1 afterwards, owned by the new write.
- Same-edge set and clear on register 4 (issue rd=4 while write-back wsel=4) → busy[4]=1.
- RSTN pulse while out_valid=1 and busy=8'hA5 → out_valid=0, busy=0 asynchronously; first post-reset instruction issues normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register-select type.
package cpu_pkg;

    localparam int REG_W = 16;
    localparam int REG_N = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] reg_sel_t;

    function automatic logic [REG_N-1:0] sel_onehot(input reg_sel_t s);
        return REG_N'(1) << s;
    endfunction

endpackage

// File: rtl/regread_stage_if.sv
// Decode-to-issue and issue-to-execute handshake bundle of the register-read stage.
interface regread_stage_if #(parameter int CTL_W = 8);
    import cpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    reg_sel_t         in_rsa;
    reg_sel_t         in_rsb;
    reg_sel_t         in_rd;
    logic             in_wen;
    logic [CTL_W-1:0] in_ctl;

    logic             out_valid;
    logic             out_ready;
    logic [REG_W-1:0] out_a;
    logic [REG_W-1:0] out_b;
    reg_sel_t         out_rd;
    logic             out_wen;
    logic [CTL_W-1:0] out_ctl;

    modport slave (
        input  in_valid, in_rsa, in_rsb, in_rd, in_wen, in_ctl, out_ready,
        output in_ready, out_valid, out_a, out_b, out_rd, out_wen, out_ctl
    );

    modport master (
        output in_valid, in_rsa, in_rsb, in_rd, in_wen, in_ctl, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_rd, out_wen, out_ctl
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard with RAW/WAW hazard detection.
// REGREAD_BYPASS_EN: a same-cycle write-back masks hazards on its register.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             issue,
    input  reg_sel_t         rsa,
    input  reg_sel_t         rsb,
    input  reg_sel_t         rd,
    input  logic             wen,
    input  logic             wb_load,
    input  reg_sel_t         wb_wsel,
    output logic [REG_N-1:0] busy,
    output logic             hazard
);

    logic [REG_N-1:0] busy_p1;
    logic [REG_N-1:0] set_vec;
    logic [REG_N-1:0] clr_vec;
    logic [REG_N-1:0] pend;

    assign set_vec = (issue && wen) ? sel_onehot(rd) : '0;
    assign clr_vec = wb_load ? sel_onehot(wb_wsel) : '0;

    // set is ORed in after the clear so a same-edge issue keeps ownership
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy_p1 <= '0;
        end else begin
            busy_p1 <= (busy_p1 & ~clr_vec) | set_vec;
        end
    end

`ifdef REGREAD_BYPASS_EN
    assign pend = busy_p1 & ~clr_vec;
`else
    assign pend = busy_p1;
`endif

    assign hazard = pend[rsa] | pend[rsb] | (wen & pend[rd]);
    assign busy   = busy_p1;

endmodule

// File: rtl/regread_stage.sv
// Register-read / issue stage: operand select, forwarding and registered issue slot.
// REGREAD_BYPASS_EN enables write-back forwarding into the operands.
module regread_stage
    import cpu_pkg::*;
#(
    parameter int CTL_W = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [REG_W-1:0] q0,
    input  logic [REG_W-1:0] q1,
    input  logic [REG_W-1:0] q2,
    input  logic [REG_W-1:0] q3,
    input  logic [REG_W-1:0] q4,
    input  logic [REG_W-1:0] q5,
    input  logic [REG_W-1:0] q6,
    input  logic [REG_W-1:0] q7,
    input  logic             wb_load,
    input  reg_sel_t         wb_wsel,
    input  logic [REG_W-1:0] wb_d,
    output logic [REG_N-1:0] busy,
    regread_stage_if.slave   bus
);

    logic [REG_W-1:0] qv [REG_N];
    logic [REG_W-1:0] opa_p0;
    logic [REG_W-1:0] opb_p0;
    logic             hazard;
    logic             issue;

    logic             vld_p1;
    logic [REG_W-1:0] a_p1;
    logic [REG_W-1:0] b_p1;
    reg_sel_t         rd_p1;
    logic             wen_p1;
    logic [CTL_W-1:0] ctl_p1;

    assign qv[0] = q0;
    assign qv[1] = q1;
    assign qv[2] = q2;
    assign qv[3] = q3;
    assign qv[4] = q4;
    assign qv[5] = q5;
    assign qv[6] = q6;
    assign qv[7] = q7;

    reg_scoreboard u_sb (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .issue   (issue),
        .rsa     (bus.in_rsa),
        .rsb     (bus.in_rsb),
        .rd      (bus.in_rd),
        .wen     (bus.in_wen),
        .wb_load (wb_load),
        .wb_wsel (wb_wsel),
        .busy    (busy),
        .hazard  (hazard)
    );

`ifdef REGREAD_BYPASS_EN
    always_comb begin
        opa_p0 = qv[bus.in_rsa];
        opb_p0 = qv[bus.in_rsb];
        if (wb_load && (wb_wsel == bus.in_rsa)) opa_p0 = wb_d;
        if (wb_load && (wb_wsel == bus.in_rsb)) opb_p0 = wb_d;
    end
`else
    logic unused_wb_d;
    assign unused_wb_d = ^wb_d;

    always_comb begin
        opa_p0 = qv[bus.in_rsa];
        opb_p0 = qv[bus.in_rsb];
    end
`endif

    assign bus.in_ready = !hazard && (!vld_p1 || bus.out_ready);
    assign issue        = bus.in_valid && bus.in_ready;

    // p0 -> p1: issue slot; data fields only change on issue
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= '0;
            wen_p1 <= 1'b0;
            ctl_p1 <= '0;
        end else if (issue) begin
            vld_p1 <= 1'b1;
            a_p1   <= opa_p0;
            b_p1   <= opb_p0;
            rd_p1  <= bus.in_rd;
            wen_p1 <= bus.in_wen;
            ctl_p1 <= bus.in_ctl;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_a     = a_p1;
    assign bus.out_b     = b_p1;
    assign bus.out_rd    = rd_p1;
    assign bus.out_wen   = wen_p1;
    assign bus.out_ctl   = ctl_p1;

endmodule
